// File: rtl/mini_src_pkg.sv
// Purpose: shared opcodes, instruction-field positions and bus-source priority for the Mini-SRC datapath.
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package mini_src_pkg;

   // ALU opcodes, IR[31:27]
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // Instruction field bit positions
   localparam int IR_OP_HI  = 31;
   localparam int IR_OP_LO  = 27;
   localparam int IR_RA_HI  = 26;
   localparam int IR_RA_LO  = 23;
   localparam int IR_RB_HI  = 22;
   localparam int IR_RB_LO  = 19;
   localparam int IR_RC_HI  = 18;
   localparam int IR_RC_LO  = 15;
   localparam int IR_C_HI   = 18;
   localparam int IR_CON_HI = 20;
   localparam int IR_CON_LO = 19;

   // Bus sources, listed from highest to lowest priority
   typedef enum logic [3:0] {
      BUS_NONE,
      BUS_REG,
      BUS_PC,
      BUS_MDR,
      BUS_ZHI,
      BUS_ZLO,
      BUS_HI,
      BUS_LO,
      BUS_INPORT,
      BUS_C
   } bus_src_e;

   // Highest-priority asserted drive select wins; nothing asserted leaves the bus idle
   function automatic bus_src_e bus_select(
      input logic reg_out,
      input logic pc_out,
      input logic mdr_out,
      input logic zhi_out,
      input logic zlo_out,
      input logic hi_out,
      input logic lo_out,
      input logic inport_out,
      input logic c_out
   );
      bus_src_e sel;
      sel = BUS_NONE;
      if (reg_out)         sel = BUS_REG;
      else if (pc_out)     sel = BUS_PC;
      else if (mdr_out)    sel = BUS_MDR;
      else if (zhi_out)    sel = BUS_ZHI;
      else if (zlo_out)    sel = BUS_ZLO;
      else if (hi_out)     sel = BUS_HI;
      else if (lo_out)     sel = BUS_LO;
      else if (inport_out) sel = BUS_INPORT;
      else if (c_out)      sel = BUS_C;
      return sel;
   endfunction

endpackage

// File: rtl/mini_src_alu.sv
// Purpose: Mini-SRC ALU, A=Y and B=bus, producing a 64-bit result (upper half used only by mul/div).
// Latency: purely combinational, zero cycles.
// Backpressure: none; result tracks inputs continuously.
module mini_src_alu
   import mini_src_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result
);

   logic [4:0]         sh;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic signed [63:0] prod;

   assign sh   = b[4:0];
   assign a_s  = a;
   assign b_s  = b;
   assign a_sx = {{32{a[31]}}, a};
   assign b_sx = {{32{b[31]}}, b};
   assign prod = a_sx * b_sx;

   // Opcode decode; unknown opcodes pass B through so the bus value can be captured in Z
   always_comb begin
      result = {32'b0, b};
      case (op)
         OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result = {32'b0, a + b};
         OP_SUB:           result = {32'b0, a - b};
         OP_AND, OP_ANDI:  result = {32'b0, a & b};
         OP_OR,  OP_ORI:   result = {32'b0, a | b};
         OP_ROR:           result = {32'b0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
         OP_ROL:           result = {32'b0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
         OP_SHR:           result = {32'b0, a >> sh};
         OP_SHRA:          result = {32'b0, a_s >>> sh};
         OP_SHL:           result = {32'b0, a << sh};
         OP_MUL:           result = prod;
         // Division by zero yields zero quotient and remainder rather than X
         OP_DIV:           result = (b == 32'b0) ? 64'b0 : {a_s % b_s, a_s / b_s};
         OP_NEG:           result = {32'b0, -b};
         OP_NOT:           result = {32'b0, ~b};
         default:          result = {32'b0, b};
      endcase
   end

endmodule

// File: rtl/mini_src_datapath.sv
// Purpose: Mini-SRC single-bus datapath: register file, PC/IR/MAR/MDR/Y/Z/HI/LO, I/O ports, CON, ALU and main memory.
// Latency: every load lands on the rising clock edge its enable is high; visible the following cycle.
// Backpressure: none; control inputs are level-sensitive and obeyed every cycle.
module mini_src_datapath
   import mini_src_pkg::*;
#(
   parameter int    MEM_WORDS = 512,
   parameter string MEM_INIT  = ""
)(
   input  logic        clock,
   input  logic        clear,
   input  logic        PCout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        MDRout,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        InPortout,
   input  logic        Cout,
   input  logic        Rout,
   input  logic        BAout,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        Rin,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        MARin,
   input  logic        MDRin,
   input  logic        Yin,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        Zhighin,
   input  logic        Zlowin,
   input  logic        OutPortin,
   input  logic        InPortin,
   input  logic        Cin,
   input  logic        CONin,
   input  logic        IncPC,
   input  logic        Read,
   input  logic        Write,
   input  logic [31:0] InPort_input,
   output logic [31:0] OutPort_out,
   output logic        CON_out
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0] r [16];
   logic [31:0] pc, ir, mar, mdr, y, z_hi, z_lo, hi, lo, in_port, out_port;
   logic        con;
   logic [31:0] mem [MEM_WORDS];

   logic [3:0]  reg_idx;
   logic [31:0] reg_val;
   logic [31:0] c_val;
   logic [31:0] bus;
   logic [31:0] mem_rd;
   logic [63:0] alu_res;
   logic        cond;
   bus_src_e    bus_sel;
   logic        mar_unused;
   logic        cin_unused;

   // Only the low address bits reach memory; Cin has no register behind it in this datapath
   assign mar_unused = ^mar[31:AW];
   assign cin_unused = Cin;

   // Memory image starts at zero
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'b0;
   end

   assign reg_idx = ({4{Gra}} & ir[IR_RA_HI:IR_RA_LO])
                  | ({4{Grb}} & ir[IR_RB_HI:IR_RB_LO])
                  | ({4{Grc}} & ir[IR_RC_HI:IR_RC_LO]);
   assign reg_val = (BAout && reg_idx == 4'd0) ? 32'b0 : r[reg_idx];
   assign c_val   = {{(31 - IR_C_HI){ir[IR_C_HI]}}, ir[IR_C_HI:0]};
   assign mem_rd  = mem[mar[AW-1:0]];
   assign bus_sel = bus_select(Rout | BAout, PCout, MDRout, Zhighout, Zlowout,
                               HIout, LOout, InPortout, Cout);

   // Single internal bus: priority-selected source, zero when idle
   always_comb begin
      bus = 32'b0;
      case (bus_sel)
         BUS_REG:    bus = reg_val;
         BUS_PC:     bus = pc;
         BUS_MDR:    bus = mdr;
         BUS_ZHI:    bus = z_hi;
         BUS_ZLO:    bus = z_lo;
         BUS_HI:     bus = hi;
         BUS_LO:     bus = lo;
         BUS_INPORT: bus = in_port;
         BUS_C:      bus = c_val;
         default:    bus = 32'b0;
      endcase
   end

   // Branch condition evaluated on the bus, chosen by the C2 field of IR
   always_comb begin
      cond = 1'b0;
      case (ir[IR_CON_HI:IR_CON_LO])
         2'b00:   cond = (bus == 32'b0);
         2'b01:   cond = (bus != 32'b0);
         2'b10:   cond = !bus[31] && (bus != 32'b0);
         default: cond = bus[31];
      endcase
   end

   mini_src_alu u_alu (
      .op     (ir[IR_OP_HI:IR_OP_LO]),
      .a      (y),
      .b      (bus),
      .result (alu_res)
   );

   // Architectural registers; clear beats every enable
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) r[i] <= 32'b0;
         pc       <= 32'b0;
         ir       <= 32'b0;
         mar      <= 32'b0;
         mdr      <= 32'b0;
         y        <= 32'b0;
         z_hi     <= 32'b0;
         z_lo     <= 32'b0;
         hi       <= 32'b0;
         lo       <= 32'b0;
         in_port  <= 32'b0;
         out_port <= 32'b0;
         con      <= 1'b0;
      end else begin
         if (Rin)       r[reg_idx] <= bus;
         if (PCin)      pc       <= IncPC ? pc + 32'd1 : bus;
         if (IRin)      ir       <= bus;
         if (MARin)     mar      <= bus;
         if (MDRin)     mdr      <= Read ? mem_rd : bus;
         if (Yin)       y        <= bus;
         if (Zhighin)   z_hi     <= alu_res[63:32];
         if (Zlowin)    z_lo     <= alu_res[31:0];
         if (HIin)      hi       <= bus;
         if (LOin)      lo       <= bus;
         if (InPortin)  in_port  <= InPort_input;
         if (OutPortin) out_port <= bus;
         if (CONin)     con      <= cond;
      end
   end

   // Memory write; a same-edge read via MDR sees the previous contents
   always_ff @(posedge clock) begin
      if (Write) mem[mar[AW-1:0]] <= mdr;
   end

   assign OutPort_out = out_port;
   assign CON_out     = con;

endmodule

// File: tb/tb_mini_src_datapath.sv
// Purpose: self-checking bench for mini_src_datapath: directed instruction sequences, ALU vector table, random ALU vs model.
// Latency: one control step per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: none.
module tb_mini_src_datapath;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] ctrl;
   logic [31:0] InPort_input;
   logic [31:0] OutPort_out;
   logic        CON_out;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   localparam logic [31:0] PCOUT = 32'd1 << 0,  ZHIGHOUT = 32'd1 << 1,  ZLOWOUT = 32'd1 << 2;
   localparam logic [31:0] MDROUT = 32'd1 << 3, HIOUT = 32'd1 << 4,     LOOUT = 32'd1 << 5;
   localparam logic [31:0] INPORTOUT = 32'd1 << 6, COUT = 32'd1 << 7,   ROUT = 32'd1 << 8;
   localparam logic [31:0] BAOUT = 32'd1 << 9,  GRA = 32'd1 << 10,      GRB = 32'd1 << 11;
   localparam logic [31:0] GRC = 32'd1 << 12,   RIN = 32'd1 << 13,      PCIN = 32'd1 << 14;
   localparam logic [31:0] IRIN = 32'd1 << 15,  MARIN = 32'd1 << 16,    MDRIN = 32'd1 << 17;
   localparam logic [31:0] YIN = 32'd1 << 18,   HIIN = 32'd1 << 19,     LOIN = 32'd1 << 20;
   localparam logic [31:0] ZHIGHIN = 32'd1 << 21, ZLOWIN = 32'd1 << 22, OUTPORTIN = 32'd1 << 23;
   localparam logic [31:0] INPORTIN = 32'd1 << 24, CIN = 32'd1 << 25,   CONIN = 32'd1 << 26;
   localparam logic [31:0] INCPC = 32'd1 << 27, READ = 32'd1 << 28,     WRITE = 32'd1 << 29;

   mini_src_datapath dut (
      .clock(clock), .clear(clear),
      .PCout(ctrl[0]), .Zhighout(ctrl[1]), .Zlowout(ctrl[2]), .MDRout(ctrl[3]),
      .HIout(ctrl[4]), .LOout(ctrl[5]), .InPortout(ctrl[6]), .Cout(ctrl[7]),
      .Rout(ctrl[8]), .BAout(ctrl[9]), .Gra(ctrl[10]), .Grb(ctrl[11]), .Grc(ctrl[12]),
      .Rin(ctrl[13]), .PCin(ctrl[14]), .IRin(ctrl[15]), .MARin(ctrl[16]), .MDRin(ctrl[17]),
      .Yin(ctrl[18]), .HIin(ctrl[19]), .LOin(ctrl[20]), .Zhighin(ctrl[21]), .Zlowin(ctrl[22]),
      .OutPortin(ctrl[23]), .InPortin(ctrl[24]), .Cin(ctrl[25]), .CONin(ctrl[26]),
      .IncPC(ctrl[27]), .Read(ctrl[28]), .Write(ctrl[29]),
      .InPort_input(InPort_input), .OutPort_out(OutPort_out), .CON_out(CON_out)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } alu_vec_t;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] bus;
      logic        exp;
   } con_vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One control step: hold the control word across exactly one rising edge
   task automatic step(input logic [31:0] c);
      ctrl = c;
      @(posedge clock);
      #1;
      ctrl = 32'b0;
   endtask

   // Put a value on the bus through the input port, together with extra controls
   task automatic drive_bus(input logic [31:0] v, input logic [31:0] c);
      InPort_input = v;
      step(INPORTIN);
      step(INPORTOUT | c);
   endtask

   // Copy the selected bus source into the output port and read it back
   task automatic observe(input logic [31:0] c, output logic [31:0] v);
      step(c | OUTPORTIN);
      v = OutPort_out;
   endtask

   task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
      drive_bus(addr, MARIN);
      drive_bus(data, MDRIN);
      step(WRITE);
   endtask

   // Eight-step ld fetch/execute
   task automatic run_ld();
      step(PCOUT | MARIN | INCPC | PCIN);
      step(READ | MDRIN);
      step(MDROUT | IRIN);
      step(GRB | BAOUT | YIN);
      step(COUT | ZLOWIN);
      step(ZLOWOUT | MARIN);
      step(READ | MDRIN);
      step(MDROUT | GRA | RIN);
   endtask

   // Reference ALU written directly from the opcode semantics
   function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x;
      longint      p, q, m;
      x = a;
      case (op)
         5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: return {32'b0, a + b};
         5'b00100: return {32'b0, a - b};
         5'b00101, 5'b01101: return {32'b0, a & b};
         5'b00110, 5'b01110: return {32'b0, a | b};
         5'b00111: begin repeat (int'(b[4:0])) x = {x[0], x[31:1]};  return {32'b0, x}; end
         5'b01000: begin repeat (int'(b[4:0])) x = {x[30:0], x[31]}; return {32'b0, x}; end
         5'b01001: return {32'b0, a >> b[4:0]};
         5'b01010: begin repeat (int'(b[4:0])) x = {x[31], x[31:1]}; return {32'b0, x}; end
         5'b01011: return {32'b0, a << b[4:0]};
         5'b01111: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
         5'b10000: begin
            if (b == 32'b0) return 64'b0;
            q = longint'($signed(a)) / longint'($signed(b));
            m = longint'($signed(a)) - q * longint'($signed(b));
            return {m[31:0], q[31:0]};
         end
         5'b10001: return {32'b0, 32'b0 - b};
         5'b10010: return {32'b0, ~b};
         default:  return {32'b0, b};
      endcase
   endfunction

   task automatic alu_run(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] v;
      drive_bus({op, 27'b0}, IRIN);
      drive_bus(a, YIN);
      drive_bus(b, ZHIGHIN | ZLOWIN);
      observe(ZLOWOUT, v);
      check({name, ".lo"}, v, exp_lo);
      observe(ZHIGHOUT, v);
      check({name, ".hi"}, v, exp_hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      alu_vec_t    tv[17];
      con_vec_t    cv[8];
      logic [31:0] v;
      logic [63:0] e;
      logic [4:0]  op;
      logic [31:0] a, b;

      tv[0]  = '{5'b00011, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000};
      tv[1]  = '{5'b00100, 32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE};
      tv[2]  = '{5'b00101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h00F000F0};
      tv[3]  = '{5'b01110, 32'hF0000000, 32'h0000000F, 32'h0,        32'hF000000F};
      tv[4]  = '{5'b00111, 32'h00000001, 32'h00000001, 32'h0,        32'h80000000};
      tv[5]  = '{5'b01000, 32'h80000001, 32'h00000004, 32'h0,        32'h00000018};
      tv[6]  = '{5'b01001, 32'h80000000, 32'h0000001F, 32'h0,        32'h00000001};
      tv[7]  = '{5'b01010, 32'h80000000, 32'h00000004, 32'h0,        32'hF8000000};
      tv[8]  = '{5'b01011, 32'h00000003, 32'h00000021, 32'h0,        32'h00000006};
      tv[9]  = '{5'b01111, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
      tv[10] = '{5'b01111, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      tv[11] = '{5'b10000, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tv[12] = '{5'b10000, 32'h00000064, 32'h00000000, 32'h0,        32'h00000000};
      tv[13] = '{5'b10001, 32'h12345678, 32'h00000001, 32'h0,        32'hFFFFFFFF};
      tv[14] = '{5'b10010, 32'h12345678, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0};
      tv[15] = '{5'b11111, 32'hAAAAAAAA, 32'h12345678, 32'h0,        32'h12345678};
      tv[16] = '{5'b00111, 32'hABCD1234, 32'h00000000, 32'h0,        32'hABCD1234};

      cv[0] = '{2'b01, 32'h00000005, 1'b1};
      cv[1] = '{2'b00, 32'h00000005, 1'b0};
      cv[2] = '{2'b00, 32'h00000000, 1'b1};
      cv[3] = '{2'b10, 32'h00000005, 1'b1};
      cv[4] = '{2'b10, 32'h00000000, 1'b0};
      cv[5] = '{2'b10, 32'h80000000, 1'b0};
      cv[6] = '{2'b11, 32'h80000000, 1'b1};
      cv[7] = '{2'b11, 32'h7FFFFFFF, 1'b0};

      clear = 1'b1;
      ctrl = 32'b0;
      InPort_input = 32'b0;
      @(posedge clock);
      #1;
      clear = 1'b0;

      // Dirty the state, then reset with every enable also asserted
      drive_bus(32'hDEADBEEF, OUTPORTIN | PCIN | IRIN | MARIN | HIIN | LOIN | YIN);
      step(INPORTOUT | ZLOWIN | CONIN);
      clear = 1'b1;
      step(INPORTOUT | OUTPORTIN | PCIN | IRIN | ZLOWIN | CONIN);
      clear = 1'b0;
      check("rst.outport", OutPort_out, 32'h0);
      check("rst.con", {31'b0, CON_out}, 32'h0);
      observe(PCOUT, v);    check("rst.pc", v, 32'h0);
      observe(COUT, v);     check("rst.ir_c", v, 32'h0);
      observe(ZLOWOUT, v);  check("rst.zlo", v, 32'h0);
      observe(ZHIGHOUT, v); check("rst.zhi", v, 32'h0);

      // ld R2,0x95
      mem_write(32'h0, 32'h01000095);
      mem_write(32'h95, 32'h1234ABCD);
      run_ld();
      observe(PCOUT, v);     check("ld1.pc", v, 32'h1);
      check("ld1.mar", dut.mar, 32'h95);
      observe(GRA | ROUT, v); check("ld1.r2", v, 32'h1234ABCD);

      // ld R0,0x38(R2)
      drive_bus(32'h01000000, IRIN);
      drive_bus(32'h00000067, GRA | RIN);
      mem_write(32'h10, 32'h00100038);
      mem_write(32'h9F, 32'hCAFE0001);
      drive_bus(32'h10, PCIN);
      run_ld();
      check("ld2.mar", dut.mar, 32'h9F);
      observe(GRA | ROUT, v); check("ld2.r0", v, 32'hCAFE0001);
      observe(PCOUT, v);      check("ld2.pc", v, 32'h11);

      // BAout reads R0 as zero, Rout does not
      drive_bus(32'h0, IRIN);
      drive_bus(32'hFFFFFFFF, GRB | RIN);
      step(GRB | BAOUT | YIN);
      step(ZLOWIN);
      observe(ZLOWOUT, v); check("baout.y", v, 32'h0);
      step(GRB | ROUT | YIN);
      step(ZLOWIN);
      observe(ZLOWOUT, v); check("rout.y", v, 32'hFFFFFFFF);

      // Bus priority and idle bus
      InPort_input = 32'h0000AAAA;
      step(INPORTIN);
      observe(INPORTOUT | COUT, v);  check("prio.inport_c", v, 32'h0000AAAA);
      observe(PCOUT | INPORTOUT, v); check("prio.pc_inport", v, 32'h11);
      observe(32'b0, v);             check("prio.idle", v, 32'h0);

      // C sign extension
      drive_bus(32'h0007FFFF, IRIN);
      observe(COUT, v); check("c.neg", v, 32'hFFFFFFFF);
      drive_bus(32'h0003FFFF, IRIN);
      observe(COUT, v); check("c.pos", v, 32'h0003FFFF);

      // HI/LO
      drive_bus(32'h13579BDF, HIIN);
      drive_bus(32'h2468ACE0, LOIN);
      observe(HIOUT, v); check("hi", v, 32'h13579BDF);
      observe(LOOUT, v); check("lo", v, 32'h2468ACE0);

      // st then read back
      drive_bus(32'h20, MARIN);
      drive_bus(32'h55AA55AA, MDRIN);
      step(WRITE);
      step(MDRIN);
      observe(MDROUT, v); check("st.mdr_zero", v, 32'h0);
      step(READ | MDRIN);
      observe(MDROUT, v); check("st.readback", v, 32'h55AA55AA);

      // Read during write returns the old word
      drive_bus(32'h11111111, MDRIN);
      step(WRITE | READ | MDRIN);
      observe(MDROUT, v); check("rdw.old", v, 32'h55AA55AA);
      step(READ | MDRIN);
      observe(MDROUT, v); check("rdw.new", v, 32'h11111111);

      // CON table
      for (int i = 0; i < 8; i++) begin
         drive_bus({11'b0, cv[i].sel, 19'b0}, IRIN);
         drive_bus(cv[i].bus, CONIN);
         check($sformatf("con[%0d]", i), {31'b0, CON_out}, {31'b0, cv[i].exp});
      end

      // ALU table
      for (int i = 0; i < 17; i++) alu_run($sformatf("alu[%0d]", i), tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo);

      // Random ALU against the reference model
      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (op == 5'b10000 && a == 32'h80000000) a = 32'h7FFFFFFF;
         e = alu_model(op, a, b);
         alu_run($sformatf("rnd[%0d] op=%b", i, op), op, a, b, e[63:32], e[31:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
